// File: rtl/subtractor_arbiter_pkg.sv
// sub_arb_pkg: shared state encoding, op codes and overflow rule for the subtractor arbiter
package sub_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

    // b_msb is always the msb of the operand as the requester supplied it, even for ADD
    function automatic logic ovf_flag(input logic op, input logic a_msb, input logic b_msb,
                                      input logic r_msb);
        return ((op == OP_ADD) ? (a_msb == b_msb) : (a_msb != b_msb)) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/subtractor.sv
// Subtractor: existing shared combinational 32-bit datapath, out = src1 - src2
module Subtractor (
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] out
);
    assign out = src1 - src2;
endmodule

// File: rtl/subtractor_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick, first set request at or above ptr (mod NREQ)
module rr_picker #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   index
);
    // scan from the farthest slot back to ptr so the closest valid request wins last
    always_comb begin
        grant = '0;
        index = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                grant = '0;
                grant[(int'(ptr) + k) % NREQ] = 1'b1;
                index = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end
endmodule

// File: rtl/subtractor_arbiter.sv
// subtractor_arbiter: round-robin sharing of one Subtractor for SUB/ADD with signed overflow
module subtractor_arbiter
    import sub_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_op,
    input  logic [NREQ*WIDTH-1:0] req_src1,
    input  logic [NREQ*WIDTH-1:0] req_src2,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  resp_ovf,
    output logic                  busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] pick;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] diff;
    logic             op_reg;

    rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick),
        .index (pick_idx)
    );

    // ADD reuses the subtractor by negating the second operand
    assign b_eff = (op_reg == OP_ADD) ? ~b_reg + WIDTH'(1) : b_reg;

    Subtractor u_sub (
        .src1 (a_reg),
        .src2 (b_eff),
        .out  (diff)
    );

    // rst_n gating keeps req_ready low during reset even while requests are pending
    assign req_ready  = (rst_n && state == IDLE) ? pick : '0;
    assign resp_valid = (state == RESP) ? (NREQ'(1) << owner) : '0;
    assign busy       = (state != IDLE);

    // accept -> execute -> hold result until the owner takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= OP_SUB;
            resp_data <= '0;
            resp_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    a_reg  <= req_src1[int'(pick_idx) * WIDTH +: WIDTH];
                    b_reg  <= req_src2[int'(pick_idx) * WIDTH +: WIDTH];
                    op_reg <= req_op[pick_idx];
                    owner  <= pick_idx;
                    state  <= EXEC;
                end
                EXEC: begin
                    resp_data <= diff;
                    resp_ovf  <= ovf_flag(op_reg, a_reg[WIDTH-1], b_reg[WIDTH-1], diff[WIDTH-1]);
                    state     <= RESP;
                end
                RESP: if (resp_ready[owner]) begin
                    rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_subtractor_arbiter.sv
// tb_subtractor_arbiter: directed plus random transactions checked against an arithmetic reference model
module tb_subtractor_arbiter;
    localparam int W = 32;
    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  req_op;
    logic [N*W-1:0] req_src1;
    logic [N*W-1:0] req_src2;
    logic [N-1:0]  resp_valid;
    logic [N-1:0]  resp_ready;
    logic [W-1:0]  resp_data;
    logic          resp_ovf;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;
    int ptr = 0;

    subtractor_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_ovf   (resp_ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_res(input logic op, input logic [31:0] a, input logic [31:0] b);
        return op ? a + b : a - b;
    endfunction

    function automatic logic model_ovf(input logic op, input logic [31:0] a, input logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint r  = op ? sa + sb : sa - sb;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    function automatic int model_winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
    task automatic txn(input logic [N-1:0] v, input logic [N-1:0] op,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1, input int hold);
        int w;
        logic [31:0] a, b, er;
        logic eo;
        logic [N-1:0] own;
        req_valid = v;
        req_op    = op;
        req_src1  = {a1, a0};
        req_src2  = {b1, b0};
        w   = model_winner(v, ptr);
        own = N'(1) << w;
        a   = w == 0 ? a0 : a1;
        b   = w == 0 ? b0 : b1;
        er  = model_res(op[w], a, b);
        eo  = model_ovf(op[w], a, b);
        #1;
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_grant", 64'(req_ready), 64'(own));
        @(negedge clk);
        chk("exec_busy", 64'(busy), 64'(1));
        chk("exec_ready", 64'(req_ready), 64'(0));
        chk("exec_rvalid", 64'(resp_valid), 64'(0));
        @(negedge clk);
        chk("resp_valid", 64'(resp_valid), 64'(own));
        chk("resp_data", 64'(resp_data), 64'(er));
        chk("resp_ovf", 64'(resp_ovf), 64'(eo));
        for (int h = 0; h < hold; h++) begin
            resp_ready = ~own;
            @(negedge clk);
            chk("hold_valid", 64'(resp_valid), 64'(own));
            chk("hold_data", 64'(resp_data), 64'(er));
            chk("hold_ready", 64'(req_ready), 64'(0));
        end
        resp_ready = own;
        @(negedge clk);
        resp_ready = '0;
        chk("done_busy", 64'(busy), 64'(0));
        chk("done_rvalid", 64'(resp_valid), 64'(0));
        ptr = (w + 1) % N;
    endtask

    initial begin
        logic [31:0] corner [6];
        corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0001};
        rst_n      = 1'b0;
        req_valid  = '1;
        req_op     = '0;
        req_src1   = '0;
        req_src2   = '0;
        resp_ready = '0;
        #12;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_data", 64'(resp_data), 64'(0));
        chk("rst_ovf", 64'(resp_ovf), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        // single requester 0
        txn(2'b01, 2'b00, 32'd4, -32'sd3, 32'd0, 32'd0, 0);
        txn(2'b01, 2'b00, -32'sd4, 32'd3, 32'd0, 32'd0, 0);
        txn(2'b01, 2'b00, -32'sd4, -32'sd3, 32'd0, 32'd0, 1);
        // both valid continuously: grants must alternate
        for (int i = 0; i < 4; i++)
            txn(2'b11, 2'b10, 32'd10, 32'd3, 32'd10, 32'd3, 0);
        // backpressure
        txn(2'b11, 2'b10, 32'd10, 32'd3, 32'd10, 32'd3, 5);
        // overflow corners
        txn(2'b01, 2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 0);
        txn(2'b10, 2'b10, 32'd0, 32'd0, 32'h7FFF_FFFF, 32'd1, 0);
        txn(2'b01, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 0);
        txn(2'b10, 2'b00, 32'd0, 32'd0, 32'd5, 32'd5, 0);
        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [31:0] r [4];
            for (int j = 0; j < 4; j++)
                r[j] = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            txn(N'($urandom_range(1, 3)), N'($urandom_range(0, 3)), r[0], r[1], r[2], r[3],
                int'($urandom_range(0, 2)));
        end
        // leave pointer at 1, then reset while EXEC
        txn(2'b01, 2'b00, 32'd9, 32'd2, 32'd0, 32'd0, 0);
        req_valid = 2'b01;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req_ready", 64'(req_ready), 64'(0));
        chk("arst_resp_valid", 64'(resp_valid), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_data", 64'(resp_data), 64'(0));
        chk("arst_ovf", 64'(resp_ovf), 64'(0));
        ptr = 0;
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_rvalid", 64'(resp_valid), 64'(0));
            chk("post_rst_busy", 64'(busy), 64'(0));
        end
        txn(2'b11, 2'b00, 32'd20, 32'd1, 32'd30, 32'd2, 0);
        req_valid = '0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
